// File: rtl/uart_reg_arb.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one UART core register-bus slave among NREQ masters.
// One access at a time; downstream bus is frozen until reg_ack or a programmable timeout.
module uart_reg_arb #(
    parameter int         NREQ     = 2,
    parameter int         TOUT     = 255,
    parameter logic [7:0] ERR_DATA = 8'hFF
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_cs,
    input  logic [NREQ-1:0]     req_wr,
    input  logic [4*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    input  logic [NREQ-1:0]     req_be,
    output logic [NREQ-1:0]     req_ack,
    output logic [NREQ-1:0]     req_err,
    output logic [7:0]          req_rdata,
    output logic [NREQ-1:0]     cur_grant,
    output logic                reg_cs,
    output logic                reg_wr,
    output logic [3:0]          reg_addr,
    output logic [7:0]          reg_wdata,
    output logic                reg_be,
    input  logic [7:0]          reg_rdata,
    input  logic                reg_ack
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]   gnt_idx, gnt_idx_nxt;
    logic [CW-1:0]   tout_cnt, tout_cnt_nxt;

    logic [NREQ-1:0] req_ack_nxt, req_err_nxt, cur_grant_nxt;
    logic [7:0]      req_rdata_nxt;
    logic            reg_cs_nxt, reg_wr_nxt, reg_be_nxt;
    logic [3:0]      reg_addr_nxt;
    logic [7:0]      reg_wdata_nxt;

    logic            win_found;
    logic [PW-1:0]   win_idx, scan_idx;
    logic            sel_wr, sel_be;
    logic [3:0]      sel_addr;
    logic [7:0]      sel_wdata;

    // Scan upward from rr_ptr so the last winner is considered last.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && req_cs[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_be    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == PW'(i)) begin
                sel_wr    = req_wr[i];
                sel_be    = req_be[i];
                sel_addr  = req_addr[4*i +: 4];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        gnt_idx_nxt   = gnt_idx;
        tout_cnt_nxt  = tout_cnt;
        cur_grant_nxt = cur_grant;
        req_ack_nxt   = '0;
        req_err_nxt   = '0;
        req_rdata_nxt = req_rdata;
        reg_cs_nxt    = reg_cs;
        reg_wr_nxt    = reg_wr;
        reg_be_nxt    = reg_be;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;

        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = ACCESS;
                    gnt_idx_nxt   = win_idx;
                    cur_grant_nxt = NREQ'(1) << win_idx;
                    reg_cs_nxt    = 1'b1;
                    reg_wr_nxt    = sel_wr;
                    reg_be_nxt    = sel_be;
                    reg_addr_nxt  = sel_addr;
                    reg_wdata_nxt = sel_wdata;
                    tout_cnt_nxt  = '0;
                end
            end
            ACCESS: begin
                tout_cnt_nxt = tout_cnt + CW'(1);
                // A slave ack in the final timeout cycle still counts as success.
                if (reg_ack) begin
                    state_nxt     = DONE;
                    reg_cs_nxt    = 1'b0;
                    req_ack_nxt   = cur_grant;
                    req_rdata_nxt = reg_rdata;
                end else if (tout_cnt == CW'(TOUT - 1)) begin
                    state_nxt     = DONE;
                    reg_cs_nxt    = 1'b0;
                    req_ack_nxt   = cur_grant;
                    req_err_nxt   = cur_grant;
                    req_rdata_nxt = ERR_DATA;
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                cur_grant_nxt = '0;
                rr_ptr_nxt    = PW'((int'(gnt_idx) + 1) % NREQ);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            tout_cnt  <= '0;
            cur_grant <= '0;
            req_ack   <= '0;
            req_err   <= '0;
            req_rdata <= '0;
            reg_cs    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_be    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            gnt_idx   <= gnt_idx_nxt;
            tout_cnt  <= tout_cnt_nxt;
            cur_grant <= cur_grant_nxt;
            req_ack   <= req_ack_nxt;
            req_err   <= req_err_nxt;
            req_rdata <= req_rdata_nxt;
            reg_cs    <= reg_cs_nxt;
            reg_wr    <= reg_wr_nxt;
            reg_be    <= reg_be_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
        end
    end

endmodule

// File: tb/tb_uart_reg_arb.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_reg_arb: directed requester stimulus, a behavioural slave,
// and a monitor that pops expected responses whenever the arbiter pulses req_ack/req_err.
module tb_uart_reg_arb;

    localparam int         NREQ     = 2;
    localparam int         TOUT     = 8;
    localparam logic [7:0] ERR_DATA = 8'hFF;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [7:0]      rdata;
    } resp_t;

    logic              mclk      = 1'b0;
    logic              reset     = 1'b1;
    logic [NREQ-1:0]   req_cs    = '0;
    logic [NREQ-1:0]   req_wr    = '0;
    logic [NREQ-1:0]   req_be    = '0;
    logic [4*NREQ-1:0] req_addr  = '0;
    logic [8*NREQ-1:0] req_wdata = '0;
    logic [7:0]        reg_rdata = '0;
    logic              reg_ack   = 1'b0;

    logic [NREQ-1:0]   req_ack, req_err, cur_grant;
    logic [7:0]        req_rdata;
    logic              reg_cs, reg_wr, reg_be;
    logic [3:0]        reg_addr;
    logic [7:0]        reg_wdata;

    int          n_checks    = 0;
    int          n_fail      = 0;
    resp_t       exp_q[$];
    int          ack_cyc_q[$];
    int          slave_delay = 1;
    logic [7:0]  slave_data  = '0;
    bit          stray_ack   = 1'b0;
    int          slave_cnt   = 0;
    int          cyc         = 0;
    int          cs_run      = 0;
    int          last_cs_len = 0;
    int          stable_viol = 0;
    int          ack_cnt     = 0;
    int          saved_acks  = 0;
    logic [3:0]  cap_addr    = '0;
    logic [7:0]  cap_wdata   = '0;
    logic        cap_wr      = 1'b0;

    uart_reg_arb #(
        .NREQ     (NREQ),
        .TOUT     (TOUT),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .mclk      (mclk),
        .reset     (reset),
        .req_cs    (req_cs),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .req_ack   (req_ack),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .cur_grant (cur_grant),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [3:0] addr, input logic [7:0] wdata);
        req_wr[i]            = wr;
        req_be[i]            = 1'b1;
        req_addr[4*i +: 4]   = addr;
        req_wdata[8*i +: 8]  = wdata;
    endtask

    // Waits at least one cycle, bounded by budget, for req_ack[i] to be seen high.
    task automatic wait_ack(input int i, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (req_ack[i] !== 1'b1 && n < budget);
        if (req_ack[i] !== 1'b1) check("ack_wait", {31'd0, req_ack[i]}, 32'd1);
    endtask

    // Slave: acks in the slave_delay-th cycle of reg_cs; slave_delay < 1 never acks.
    initial begin : slave
        forever begin
            @(negedge mclk);
            reg_ack = 1'b0;
            if (reg_cs) begin
                slave_cnt++;
                if (slave_cnt == slave_delay) begin
                    reg_ack   = 1'b1;
                    reg_rdata = slave_data;
                end
            end else begin
                slave_cnt = 0;
            end
            if (stray_ack) begin
                reg_ack   = 1'b1;
                reg_rdata = 8'hEE;
                stray_ack = 1'b0;
            end
        end
    end

    initial begin : monitor
        resp_t exp_r;
        forever begin
            @(negedge mclk);
            if (reg_cs) begin
                if (cs_run == 0) begin
                    cap_addr  = reg_addr;
                    cap_wdata = reg_wdata;
                    cap_wr    = reg_wr;
                end else if (reg_addr !== cap_addr || reg_wdata !== cap_wdata || reg_wr !== cap_wr) begin
                    stable_viol++;
                end
                cs_run++;
            end else if (cs_run != 0) begin
                last_cs_len = cs_run;
                cs_run      = 0;
            end
            if (req_ack != '0 || req_err != '0) begin
                ack_cnt++;
                ack_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", {28'd0, req_ack, req_err}, 32'd0);
                end else begin
                    exp_r = exp_q.pop_front();
                    check("resp_ack",   {30'd0, req_ack}, {30'd0, exp_r.ack});
                    check("resp_err",   {30'd0, req_err}, {30'd0, exp_r.err});
                    check("resp_rdata", {24'd0, req_rdata}, {24'd0, exp_r.rdata});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge mclk);
        check("rst_reg_cs",    {31'd0, reg_cs}, 32'd0);
        check("rst_cur_grant", {30'd0, cur_grant}, 32'd0);
        check("rst_req_ack",   {30'd0, req_ack}, 32'd0);
        check("rst_req_err",   {30'd0, req_err}, 32'd0);
        check("rst_req_rdata", {24'd0, req_rdata}, 32'd0);
        check("rst_reg_addr",  {28'd0, reg_addr}, 32'd0);
        reset = 1'b0;
        @(negedge mclk);

        // Single read: req0 addr 3, slave acks in the 2nd access cycle with 5A
        slave_delay = 2;
        slave_data  = 8'h5A;
        set_req(0, 1'b0, 4'h3, 8'h00);
        exp_q.push_back(resp_t'{ack: 2'b01, err: 2'b00, rdata: 8'h5A});
        req_cs[0] = 1'b1;
        @(negedge mclk);
        check("rd_reg_cs",    {31'd0, reg_cs}, 32'd1);
        check("rd_reg_addr",  {28'd0, reg_addr}, 32'h3);
        check("rd_reg_wr",    {31'd0, reg_wr}, 32'd0);
        check("rd_cur_grant", {30'd0, cur_grant}, 32'b01);
        wait_ack(0, 20);
        req_cs[0] = 1'b0;
        @(negedge mclk);
        check("rd_cs_len", last_cs_len, 32'd2);
        repeat (2) @(negedge mclk);

        // Round-robin: both held, zero-latency slave; rr_ptr is 1 after req0 won
        slave_delay = 1;
        slave_data  = 8'h77;
        set_req(0, 1'b0, 4'h5, 8'h00);
        set_req(1, 1'b0, 4'h9, 8'h00);
        exp_q.push_back(resp_t'{ack: 2'b10, err: 2'b00, rdata: 8'h77});
        exp_q.push_back(resp_t'{ack: 2'b01, err: 2'b00, rdata: 8'h77});
        exp_q.push_back(resp_t'{ack: 2'b10, err: 2'b00, rdata: 8'h77});
        exp_q.push_back(resp_t'{ack: 2'b01, err: 2'b00, rdata: 8'h77});
        ack_cyc_q.delete();
        req_cs = 2'b11;
        wait_ack(1, 20);
        wait_ack(0, 20);
        wait_ack(1, 20);
        wait_ack(0, 20);
        req_cs = 2'b00;
        @(negedge mclk);
        check("rr_ack_count", ack_cyc_q.size(), 32'd4);
        if (ack_cyc_q.size() == 4) begin
            for (int k = 1; k < 4; k++) check("rr_gap", ack_cyc_q[k] - ack_cyc_q[k-1], 32'd3);
        end
        repeat (2) @(negedge mclk);

        // Timeout: req1 writes C3 to addr 1, slave never acks
        slave_delay = 0;
        set_req(1, 1'b1, 4'h1, 8'hC3);
        exp_q.push_back(resp_t'{ack: 2'b10, err: 2'b10, rdata: ERR_DATA});
        req_cs[1] = 1'b1;
        @(negedge mclk);
        check("to_reg_wr",    {31'd0, reg_wr}, 32'd1);
        check("to_reg_addr",  {28'd0, reg_addr}, 32'h1);
        check("to_reg_wdata", {24'd0, reg_wdata}, 32'hC3);
        check("to_cur_grant", {30'd0, cur_grant}, 32'b10);
        wait_ack(1, 30);
        req_cs[1] = 1'b0;
        @(negedge mclk);
        check("to_cs_len", last_cs_len, 32'd8);
        saved_acks = ack_cnt;
        stray_ack  = 1'b1;
        repeat (5) @(negedge mclk);
        check("stray_ack_count", ack_cnt, saved_acks);
        check("stray_reg_cs",    {31'd0, reg_cs}, 32'd0);
        check("stray_grant",     {30'd0, cur_grant}, 32'd0);

        // Ack/timeout tie: ack arrives in the last (TOUT-th) access cycle
        slave_delay = TOUT;
        slave_data  = 8'h3C;
        set_req(0, 1'b0, 4'h7, 8'h00);
        exp_q.push_back(resp_t'{ack: 2'b01, err: 2'b00, rdata: 8'h3C});
        req_cs[0] = 1'b1;
        wait_ack(0, 30);
        req_cs[0] = 1'b0;
        @(negedge mclk);
        check("tie_cs_len", last_cs_len, 32'd8);
        repeat (2) @(negedge mclk);

        // Input stability: requester changes its fields during the access
        slave_delay = 4;
        slave_data  = 8'h9D;
        stable_viol = 0;
        set_req(0, 1'b1, 4'h2, 8'h55);
        exp_q.push_back(resp_t'{ack: 2'b01, err: 2'b00, rdata: 8'h9D});
        req_cs[0] = 1'b1;
        @(negedge mclk);
        set_req(0, 1'b0, 4'hF, 8'hAA);
        wait_ack(0, 30);
        req_cs[0] = 1'b0;
        @(negedge mclk);
        check("stab_viol",     stable_viol, 32'd0);
        check("stab_reg_addr", {28'd0, reg_addr}, 32'h2);
        check("stab_wdata",    {24'd0, reg_wdata}, 32'h55);
        check("stab_cs_len",   last_cs_len, 32'd4);
        repeat (2) @(negedge mclk);

        // Reset mid-access, then req1 alone is granted first
        slave_delay = 0;
        set_req(0, 1'b0, 4'h4, 8'h00);
        req_cs[0] = 1'b1;
        @(negedge mclk);
        check("mr_grant_pre", {30'd0, cur_grant}, 32'b01);
        @(negedge mclk);
        reset = 1'b1;
        @(negedge mclk);
        check("mr_reg_cs",  {31'd0, reg_cs}, 32'd0);
        check("mr_grant",   {30'd0, cur_grant}, 32'd0);
        check("mr_req_ack", {30'd0, req_ack}, 32'd0);
        reset       = 1'b0;
        slave_delay = 1;
        slave_data  = 8'h42;
        set_req(1, 1'b0, 4'h6, 8'h00);
        exp_q.push_back(resp_t'{ack: 2'b10, err: 2'b00, rdata: 8'h42});
        req_cs = 2'b10;
        @(negedge mclk);
        check("mr_new_grant", {30'd0, cur_grant}, 32'b10);
        check("mr_new_addr",  {28'd0, reg_addr}, 32'h6);
        wait_ack(1, 20);
        req_cs = 2'b00;
        repeat (3) @(negedge mclk);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
